// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifq_pkg;

    localparam logic [31:0] INSTR_BYTES   = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous in-order FIFO of {pc, instr} entries with flush and head read.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  ifq_entry_t                 push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output ifq_entry_t                 head_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    ifq_entry_t    mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count;

    // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[tail_ptr] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_i) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop_i) begin
                head_ptr <= head_ptr + 1'b1;
            end
            count <= count + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o = count;
    assign empty_o = (count == '0);
    assign head_o  = mem[head_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled fetch front end: credit-limited requests, in-order response queue, redirect flush.
// Optional IFQ_BYPASS_EN presents a response to decode in its arrival cycle when the queue is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [31:0]                imem_rdata_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                instr_pc_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] q_count_o
);
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    ifq_state_e    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] occupancy;
    logic          gnt_acc;
    logic          rsp_acc;
    logic          rsp_live;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    ifq_entry_t    head;
    ifq_entry_t    push_entry;

    assign redirect_target = redirect_pc_i & PC_ALIGN_MASK;

    // Queued plus in-flight words never exceed DEPTH, so the queue cannot overflow.
    assign imem_req_o  = !rst_i && (state == FETCH)
                         && (({1'b0, occupancy} + {1'b0, outstanding}) < CREDITS);
    assign imem_addr_o = fetch_pc;
    assign gnt_acc     = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding belongs to a request issued before reset.
    assign rsp_acc  = imem_rvalid_i && (outstanding != '0);
    assign rsp_live = rsp_acc && (drop_cnt == '0) && !redirect_i;

    assign outstanding_next = outstanding + CW'(gnt_acc) - CW'(rsp_acc);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        drop_next = drop_cnt;
        if (redirect_i) begin
            drop_next = outstanding_next;
        end else if (rsp_acc && (drop_cnt != '0)) begin
            drop_next = drop_cnt - 1'b1;
        end
    end

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_live && fifo_empty && instr_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push       = rsp_live && !bypass;
    assign pop        = !fifo_empty && instr_ready_i && !redirect_i;
    assign push_entry = '{pc: resp_pc, instr: imem_rdata_i};

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .count_o    (occupancy),
        .empty_o    (fifo_empty),
        .head_o     (head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            if (redirect_i) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
            end else begin
                if (gnt_acc) begin
                    fetch_pc <= fetch_pc + INSTR_BYTES;
                end
                if (rsp_live) begin
                    resp_pc <= resp_pc + INSTR_BYTES;
                end
            end
            // Stay in DRAIN until every stale response has been swallowed.
            if (redirect_i || (state == DRAIN)) begin
                state <= (drop_next != '0) ? DRAIN : FETCH;
            end
        end
    end

    always_comb begin
        instr_valid_o = !fifo_empty;
        instr_o       = '0;
        instr_pc_o    = '0;
        if (bypass) begin
            instr_valid_o = 1'b1;
            instr_o       = imem_rdata_i;
            instr_pc_o    = resp_pc;
        end else if (!fifo_empty) begin
            instr_o    = head.instr;
            instr_pc_o = head.pc;
        end
    end

    assign q_count_o = occupancy;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: epoch-tagged memory model, expected-delivery queue, random and directed stimulus.
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [31:0]   imem_rdata_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          instr_valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   instr_pc_o;
    logic          instr_ready_i;
    logic [CW-1:0] q_count_o;

    ifetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ready_i(instr_ready_i),
        .q_count_o    (q_count_o)
    );

    always #5 clk = ~clk;

    req_t        inflight[$];
    ifq_entry_t  exp_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pc_log[$];
    int          epoch;
    int          occ;
    int          orphans;
    bit          drove_orphan;
    logic [31:0] exp_addr;
    int          tests;
    int          failed;
    ifq_entry_t  mon_e;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] log_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode-side monitor: every accepted instruction must be the oldest live grant.
    always @(negedge clk) begin
        if (!rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_delivery: got pc %h expected none at %0t", instr_pc_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("deliver_pc", instr_pc_o, mon_e.pc);
                check("deliver_instr", instr_o, mon_e.instr);
                pc_log.push_back(instr_pc_o);
            end
        end
    end

    // Reference model: credits, occupancy and fetch address from the protocol rules.
    task automatic model();
        int stale = 0;
        int pre   = occ;
        bit ereq;
        bit live  = 1'b0;
        bit byp;
        bit rsp   = imem_rvalid_i && !drove_orphan;
        foreach (inflight[i]) if (inflight[i].epoch != epoch) stale++;
        ereq = (stale == 0) && ((pre + inflight.size()) < DEPTH);
        if (rsp) live = (inflight[0].epoch == epoch) && !redirect_i;
        byp = BYP && live && (pre == 0) && instr_ready_i;
        check("imem_req", 32'(imem_req_o), 32'(ereq));
        check("instr_valid", 32'(instr_valid_o), 32'((pre != 0) || byp));
        check("q_count", 32'(q_count_o), 32'(pre));
        if (imem_req_o && imem_gnt_i) begin
            check("imem_addr", imem_addr_o, exp_addr);
            inflight.push_back('{addr: exp_addr, epoch: epoch});
            if (!redirect_i) exp_q.push_back('{pc: exp_addr, instr: word_of(exp_addr)});
            gnt_log.push_back(exp_addr);
            exp_addr = exp_addr + 32'd4;
        end
        if (rsp) void'(inflight.pop_front());
        if (redirect_i) begin
            epoch++;
            occ = 0;
            exp_q.delete();
            exp_addr = redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            occ = pre + int'(live && !byp) - int'(instr_valid_o && instr_ready_i && (pre != 0));
        end
    endtask

    task automatic drive(input bit g, input bit rv, input bit rdy, input bit redir, input logic [31:0] rpc);
        imem_gnt_i    = g;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        drove_orphan  = 1'b0;
        if (rv && orphans > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
            drove_orphan  = 1'b1;
            orphans--;
        end else if (rv && inflight.size() != 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word_of(inflight[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst_i) model();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit g, input bit rv, input bit rdy, input bit redir, input logic [31:0] rpc);
        drive(g, rv, rdy, redir, rpc);
        tick();
    endtask

    task automatic drain();
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        gnt_log.delete();
        pc_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        tests = 0; failed = 0; epoch = 0; occ = 0; orphans = 0;
        exp_addr = 32'h0; drove_orphan = 1'b0;
        rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
        check("rst_count", 32'(q_count_o), 32'd0);
        rst_i = 1'b0;

        // Back-to-back fetch from reset with immediate grants and one-cycle responses.
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", log_at(gnt_log, i), 32'(4 * i));
            check("seq_pc", log_at(pc_log, i), 32'(4 * i));
        end

        // Fill to DEPTH with decode stalled, then free one slot.
        drain();
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("full_grants", 32'(gnt_log.size()), 32'(DEPTH));
        check("full_count", 32'(q_count_o), 32'(DEPTH));
        check("full_req", 32'(imem_req_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("slot_req", 32'(imem_req_o), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("slot_grants", 32'(gnt_log.size()), 32'(DEPTH + 1));

        // Redirect with three requests in flight.
        drain();
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        gnt_log.delete();
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("drain_count", 32'(q_count_o), 32'd0);
        check("drain_grants", 32'(gnt_log.size()), 32'd0);
        repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_addr", log_at(gnt_log, 0), 32'h0000_0100);
        check("redir_pc", log_at(pc_log, 0), 32'h0000_0100);

        // Redirect coinciding with a response and a decode accept, two entries queued.
        drain();
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_flush_count", 32'(q_count_o), 32'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        check("flush_count", 32'(q_count_o), 32'd0);
        check("flush_valid", 32'(instr_valid_o), 32'd0);
        check("flush_no_pop", 32'(pc_log.size()), 32'd0);
        repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("flush_next_pc", log_at(pc_log, 0), 32'h0000_0200);

        // PC wrap and redirect alignment.
        drain();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        gnt_log.delete();
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("wrap_addr0", log_at(gnt_log, 0), 32'hFFFF_FFFC);
        check("wrap_addr1", log_at(gnt_log, 1), 32'h0000_0000);
        drain();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        gnt_log.delete();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("align_addr", log_at(gnt_log, 0), 32'h0000_0100);

        // Response into an empty queue with decode ready.
        drain();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("byp_same_valid", 32'(instr_valid_o), 32'(BYP));
        check("byp_same_count", 32'(q_count_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("byp_next_valid", 32'(instr_valid_o), 32'(!BYP));
        check("byp_next_count", 32'(q_count_o), 32'(!BYP));
        tick();

        // Reset with requests in flight: their late responses must be ignored.
        drain();
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst_i = 1'b0;
        inflight.delete();
        exp_q.delete();
        occ = 0;
        epoch++;
        exp_addr = 32'h0;
        orphans = 2;
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("orphan_count", 32'(q_count_o), 32'd0);
        check("orphan_valid", 32'(instr_valid_o), 32'd0);
        gnt_log.delete();
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("post_rst_addr", log_at(gnt_log, 0), 32'h0000_0000);

        // Random traffic against the model.
        repeat (3000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom);
        end
        drain();
        check("end_exp_empty", 32'(exp_q.size()), 32'd0);
        check("end_inflight_empty", 32'(inflight.size()), 32'd0);
        check("end_count", 32'(q_count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
